// File: rtl/axi_app_mmu_err_slave.sv
// AXI3 error slave: accepts any access, answers with P_RESP and constant read data.
// Optional first-fault capture register enabled by AXI_APP_MMU_ERR_SLAVE_FAULT_CAPTURE_EN.
module axi_app_mmu_err_slave #(
    parameter int          P_AXI_IDWIDTH = 4,
    parameter logic [1:0]  P_RESP        = 2'b11,
    parameter logic [63:0] P_RDATA       = 64'h0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              axis_awaddr,
    input  logic [3:0]               axis_awlen,
    input  logic [2:0]               axis_awsize,
    input  logic [1:0]               axis_awburst,
    input  logic [P_AXI_IDWIDTH-1:0] axis_awid,
    input  logic                     axis_awvalid,
    output logic                     axis_awready,
    input  logic [P_AXI_IDWIDTH-1:0] axis_wid,
    input  logic [63:0]              axis_wdata,
    input  logic [7:0]               axis_wstrb,
    input  logic                     axis_wlast,
    input  logic                     axis_wvalid,
    output logic                     axis_wready,
    output logic [1:0]               axis_bresp,
    output logic [P_AXI_IDWIDTH-1:0] axis_bid,
    output logic                     axis_bvalid,
    input  logic                     axis_bready,
    input  logic [31:0]              axis_araddr,
    input  logic [3:0]               axis_arlen,
    input  logic [2:0]               axis_arsize,
    input  logic [1:0]               axis_arburst,
    input  logic [P_AXI_IDWIDTH-1:0] axis_arid,
    input  logic                     axis_arvalid,
    output logic                     axis_arready,
    output logic [63:0]              axis_rdata,
    output logic [1:0]               axis_rresp,
    output logic [P_AXI_IDWIDTH-1:0] axis_rid,
    output logic                     axis_rlast,
    output logic                     axis_rvalid,
    input  logic                     axis_rready,
    output logic [31:0]              fault_addr,
    output logic                     fault_wr,
    output logic                     fault_valid,
    input  logic                     fault_clr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        WRESP = 2'd2,
        RDATA = 2'd3
    } state_t;

    state_t                   state_q;
    logic                     wready_q;
    logic                     bvalid_q;
    logic                     rvalid_q;
    logic                     rlast_q;
    logic [P_AXI_IDWIDTH-1:0] bid_q;
    logic [P_AXI_IDWIDTH-1:0] rid_q;
    logic [3:0]               cnt_q;

    logic aw_hs;
    logic ar_hs;

    // A pending write blocks the read channel, so writes win simultaneous requests.
    assign axis_awready = (state_q == IDLE);
    assign axis_arready = (state_q == IDLE) && !axis_awvalid;
    assign aw_hs        = axis_awready && axis_awvalid;
    assign ar_hs        = axis_arready && axis_arvalid;

    assign axis_wready = wready_q;
    assign axis_bvalid = bvalid_q;
    assign axis_bresp  = P_RESP;
    assign axis_bid    = bid_q;
    assign axis_rvalid = rvalid_q;
    assign axis_rlast  = rlast_q;
    assign axis_rid    = rid_q;
    assign axis_rdata  = P_RDATA;
    assign axis_rresp  = P_RESP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wready_q <= 1'b0;
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            bid_q    <= '0;
            rid_q    <= '0;
            cnt_q    <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (aw_hs) begin
                        bid_q    <= axis_awid;
                        wready_q <= 1'b1;
                        state_q  <= WDATA;
                    end else if (ar_hs) begin
                        rid_q    <= axis_arid;
                        cnt_q    <= axis_arlen;
                        rvalid_q <= 1'b1;
                        rlast_q  <= (axis_arlen == 4'd0);
                        state_q  <= RDATA;
                    end
                end
                // Burst length is taken from wlast only; awlen is not trusted.
                WDATA: begin
                    if (axis_wvalid && axis_wlast) begin
                        wready_q <= 1'b0;
                        bvalid_q <= 1'b1;
                        state_q  <= WRESP;
                    end
                end
                WRESP: begin
                    if (axis_bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                RDATA: begin
                    if (axis_rready) begin
                        if (cnt_q == 4'd0) begin
                            rvalid_q <= 1'b0;
                            rlast_q  <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            cnt_q   <= cnt_q - 4'd1;
                            rlast_q <= (cnt_q == 4'd1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef AXI_APP_MMU_ERR_SLAVE_FAULT_CAPTURE_EN
    logic [31:0] fault_addr_q;
    logic        fault_wr_q;
    logic        fault_valid_q;

    // A clear coinciding with a new fault still records the new fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_addr_q  <= 32'd0;
            fault_wr_q    <= 1'b0;
            fault_valid_q <= 1'b0;
        end else if ((aw_hs || ar_hs) && (!fault_valid_q || fault_clr)) begin
            fault_addr_q  <= aw_hs ? axis_awaddr : axis_araddr;
            fault_wr_q    <= aw_hs;
            fault_valid_q <= 1'b1;
        end else if (fault_clr) begin
            fault_valid_q <= 1'b0;
        end
    end

    assign fault_addr  = fault_addr_q;
    assign fault_wr    = fault_wr_q;
    assign fault_valid = fault_valid_q;
`else
    assign fault_addr  = 32'd0;
    assign fault_wr    = 1'b0;
    assign fault_valid = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{axis_awaddr, axis_awlen, axis_awsize, axis_awburst,
                         axis_wid, axis_wdata, axis_wstrb,
                         axis_araddr, axis_arsize, axis_arburst, fault_clr};

endmodule

// File: tb/tb_axi_app_mmu_err_slave.sv
// Scoreboard bench for axi_app_mmu_err_slave; expected B/R responses are queued at stimulus time.
// Define AXI_APP_MMU_ERR_SLAVE_FAULT_CAPTURE_EN to exercise the fault capture register.
module tb_axi_app_mmu_err_slave;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic [3:0]  id;
        logic        last;
    } rbeat_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awid;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arid;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [31:0] fault_addr;
    logic        fault_wr;
    logic        fault_valid;
    logic        fault_clr;

    int errors;
    int checks;

    logic [3:0] bq[$];
    rbeat_t     rq[$];

    axi_app_mmu_err_slave dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .axis_awaddr  (awaddr),
        .axis_awlen   (awlen),
        .axis_awsize  (awsize),
        .axis_awburst (awburst),
        .axis_awid    (awid),
        .axis_awvalid (awvalid),
        .axis_awready (awready),
        .axis_wid     (wid),
        .axis_wdata   (wdata),
        .axis_wstrb   (wstrb),
        .axis_wlast   (wlast),
        .axis_wvalid  (wvalid),
        .axis_wready  (wready),
        .axis_bresp   (bresp),
        .axis_bid     (bid),
        .axis_bvalid  (bvalid),
        .axis_bready  (bready),
        .axis_araddr  (araddr),
        .axis_arlen   (arlen),
        .axis_arsize  (arsize),
        .axis_arburst (arburst),
        .axis_arid    (arid),
        .axis_arvalid (arvalid),
        .axis_arready (arready),
        .axis_rdata   (rdata),
        .axis_rresp   (rresp),
        .axis_rid     (rid),
        .axis_rlast   (rlast),
        .axis_rvalid  (rvalid),
        .axis_rready  (rready),
        .fault_addr   (fault_addr),
        .fault_wr     (fault_wr),
        .fault_valid  (fault_valid),
        .fault_clr    (fault_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one write: AW, nbeats W beats (wlast on the final one), expect one B next cycle.
    task automatic do_write(input logic [31:0] addr, input logic [3:0] id,
                            input logic [3:0] len, input int nbeats);
        int     nb;
        logic [3:0] exp_id;
        awaddr  = addr;
        awid    = id;
        awlen   = len;
        awsize  = 3'd3;
        awburst = 2'b01;
        awvalid = 1'b1;
        bready  = 1'b1;
        @(negedge clk);
        checks++;
        if (awready !== 1'b1) begin
            errors++;
            $display("FAIL aw_ready: got %b want 1", awready);
        end
        tick();
        awvalid = 1'b0;
        bq.push_back(id);
        for (int i = 0; i < nbeats; i++) begin
            wvalid = 1'b1;
            wlast  = (i == nbeats - 1);
            wdata  = 64'hDEAD_0000_0000_0000 | 64'(i);
            wstrb  = 8'hFF;
            wid    = id;
            @(negedge clk);
            checks++;
            if (wready !== 1'b1 || bvalid !== 1'b0) begin
                errors++;
                $display("FAIL w_beat%0d: wready=%b bvalid=%b want wready=1 bvalid=0", i, wready, bvalid);
            end
            tick();
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        nb = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bvalid === 1'b1) begin
                checks++;
                if (nb == 0 && c != 0) begin
                    errors++;
                    $display("FAIL b_latency: bvalid after %0d extra cycles want 0", c);
                end
                if (bq.size() == 0) begin
                    errors++;
                    $display("FAIL b_unexpected: extra B bid=%0d want none", bid);
                end else begin
                    exp_id = bq.pop_front();
                    if (bid !== exp_id || bresp !== 2'b11) begin
                        errors++;
                        $display("FAIL b_resp: bid=%0d bresp=%b want bid=%0d bresp=11", bid, bresp, exp_id);
                    end
                end
                nb++;
            end
            tick();
        end
        checks++;
        if (nb != 1) begin
            errors++;
            $display("FAIL b_count: got %0d B responses want 1", nb);
        end
        bq.delete();
        $display("write addr=%h id=%0d len=%0d beats=%0d -> %0d B", addr, id, len, nbeats, nb);
    endtask

    // Issue one read and drain it; toggle=1 stalls rready every other cycle.
    task automatic do_read(input logic [31:0] addr, input logic [3:0] id,
                           input logic [3:0] len, input bit toggle);
        rbeat_t exp_b;
        rbeat_t prev_b;
        rbeat_t cur_b;
        bit     stall_prev;
        int     nbeats;
        araddr  = addr;
        arid    = id;
        arlen   = len;
        arsize  = 3'd3;
        arburst = 2'b01;
        arvalid = 1'b1;
        rready  = 1'b0;
        @(negedge clk);
        checks++;
        if (arready !== 1'b1) begin
            errors++;
            $display("FAIL ar_ready: got %b want 1", arready);
        end
        tick();
        arvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            exp_b.data = 64'h0;
            exp_b.resp = 2'b11;
            exp_b.id   = id;
            exp_b.last = (k == int'(len));
            rq.push_back(exp_b);
        end
        stall_prev = 1'b0;
        prev_b     = '0;
        nbeats     = 0;
        for (int c = 0; c < 200 && rq.size() > 0; c++) begin
            rready = toggle ? ((c % 2) == 1) : 1'b1;
            @(negedge clk);
            cur_b = {rdata, rresp, rid, rlast};
            checks++;
            if (rvalid !== 1'b1) begin
                errors++;
                $display("FAIL r_valid_c%0d: rvalid=%b want 1", c, rvalid);
            end
            if (stall_prev) begin
                checks++;
                if (cur_b !== prev_b) begin
                    errors++;
                    $display("FAIL r_stable: got %h want %h", cur_b, prev_b);
                end
            end
            if (rvalid === 1'b1 && rready) begin
                exp_b = rq.pop_front();
                checks++;
                if (cur_b !== exp_b) begin
                    errors++;
                    $display("FAIL r_beat%0d: data=%h resp=%b id=%0d last=%b want data=%h resp=%b id=%0d last=%b",
                             nbeats, rdata, rresp, rid, rlast, exp_b.data, exp_b.resp, exp_b.id, exp_b.last);
                end
                nbeats++;
            end
            stall_prev = (rvalid === 1'b1) && !rready;
            prev_b     = cur_b;
            tick();
        end
        checks++;
        if (rq.size() != 0) begin
            errors++;
            $display("FAIL r_timeout: %0d beats outstanding want 0", rq.size());
        end
        rq.delete();
        rready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (rvalid !== 1'b0) begin
                errors++;
                $display("FAIL r_extra: rvalid=%b want 0", rvalid);
            end
            tick();
        end
        rready = 1'b0;
        $display("read addr=%h id=%0d len=%0d toggle=%0d -> %0d beats", addr, id, len, toggle, nbeats);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({bvalid, rvalid, rlast, wready, bid, rid, fault_valid, fault_addr, fault_wr} !== '0) begin
            errors++;
            $display("FAIL reset_values: bv=%b rv=%b rl=%b wr=%b bid=%0d rid=%0d fv=%b fa=%h fw=%b want all 0",
                     bvalid, rvalid, rlast, wready, bid, rid, fault_valid, fault_addr, fault_wr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (awready !== 1'b1) begin
            errors++;
            $display("FAIL reset_awready: got %b want 1", awready);
        end
        $display("reset released awready=%b", awready);
    endtask

    task automatic test_write();
        do_write(32'h0200_1000, 4'd3, 4'd3, 4);
        do_write(32'h0000_4000, 4'd9, 4'd5, 2);
    endtask

    task automatic test_read();
        do_read(32'h0000_8000, 4'd5, 4'd7, 1'b0);
        do_read(32'h0000_8100, 4'd6, 4'd0, 1'b1);
        do_read(32'h0000_8200, 4'd15, 4'd2, 1'b1);
    endtask

    task automatic test_aw_ar_collision();
        bit b_seen;
        awaddr  = 32'h0000_0A00;
        awid    = 4'd1;
        awlen   = 4'd0;
        awvalid = 1'b1;
        araddr  = 32'h0000_0B00;
        arid    = 4'd2;
        arlen   = 4'd0;
        arvalid = 1'b1;
        bready  = 1'b1;
        rready  = 1'b0;
        @(negedge clk);
        checks++;
        if (awready !== 1'b1 || arready !== 1'b0) begin
            errors++;
            $display("FAIL collide_ready: awready=%b arready=%b want 1 0", awready, arready);
        end
        tick();
        awvalid = 1'b0;
        bq.push_back(4'd1);
        wvalid  = 1'b1;
        wlast   = 1'b1;
        @(negedge clk);
        checks++;
        if (arready !== 1'b0) begin
            errors++;
            $display("FAIL collide_wdata_arready: got %b want 0", arready);
        end
        tick();
        wvalid = 1'b0;
        wlast  = 1'b0;
        b_seen = 1'b0;
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b1 || arready !== 1'b0 || bid !== bq[0]) begin
            errors++;
            $display("FAIL collide_b: bvalid=%b arready=%b bid=%0d want 1 0 %0d", bvalid, arready, bid, bq[0]);
        end else begin
            b_seen = 1'b1;
        end
        void'(bq.pop_front());
        tick();
        @(negedge clk);
        checks++;
        if (arready !== 1'b1) begin
            errors++;
            $display("FAIL collide_ar_after_b: arready=%b want 1", arready);
        end
        tick();
        arvalid = 1'b0;
        rready  = 1'b1;
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b1 || rid !== 4'd2 || rlast !== 1'b1) begin
            errors++;
            $display("FAIL collide_r: rvalid=%b rid=%0d rlast=%b want 1 2 1", rvalid, rid, rlast);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL collide_r_done: rvalid=%b want 0", rvalid);
        end
        tick();
        rready = 1'b0;
        $display("collision write-first b_seen=%0d then read rid=2", b_seen);
    endtask

    task automatic test_reset_mid_burst();
        int strays;
        araddr  = 32'h0000_C000;
        arid    = 4'd4;
        arlen   = 4'd7;
        arvalid = 1'b1;
        rready  = 1'b1;
        tick();
        arvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b1 || rlast !== 1'b0) begin
            errors++;
            $display("FAIL midreset_beat3: rvalid=%b rlast=%b want 1 0", rvalid, rlast);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rvalid !== 1'b0 || rid !== 4'd0) begin
            errors++;
            $display("FAIL midreset_async: rvalid=%b rid=%0d want 0 0", rvalid, rid);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (awready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_awready: got %b want 1", awready);
        end
        strays = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rvalid !== 1'b0) strays++;
            tick();
        end
        checks++;
        if (strays != 0) begin
            errors++;
            $display("FAIL midreset_strays: %0d stray beats want 0", strays);
        end
        rready = 1'b0;
        $display("reset during beat 3 strays=%0d", strays);
    endtask

`ifdef AXI_APP_MMU_ERR_SLAVE_FAULT_CAPTURE_EN
    task automatic test_fault_capture();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (fault_valid !== 1'b0) begin
            errors++;
            $display("FAIL fault_clear: fault_valid=%b want 0", fault_valid);
        end
        tick();
        do_read(32'h0000_0100, 4'd1, 4'd0, 1'b0);
        do_write(32'h0000_0200, 4'd2, 4'd0, 1);
        @(negedge clk);
        checks++;
        if (fault_addr !== 32'h100 || fault_wr !== 1'b0 || fault_valid !== 1'b1) begin
            errors++;
            $display("FAIL fault_first: addr=%h wr=%b valid=%b want 00000100 0 1", fault_addr, fault_wr, fault_valid);
        end
        tick();
        awaddr    = 32'h0000_0300;
        awid      = 4'd7;
        awlen     = 4'd0;
        awvalid   = 1'b1;
        fault_clr = 1'b1;
        bready    = 1'b1;
        tick();
        awvalid   = 1'b0;
        fault_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (fault_addr !== 32'h300 || fault_wr !== 1'b1 || fault_valid !== 1'b1) begin
            errors++;
            $display("FAIL fault_clr_new: addr=%h wr=%b valid=%b want 00000300 1 1", fault_addr, fault_wr, fault_valid);
        end
        wvalid = 1'b1;
        wlast  = 1'b1;
        tick();
        wvalid = 1'b0;
        wlast  = 1'b0;
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b1 || bid !== 4'd7) begin
            errors++;
            $display("FAIL fault_write_b: bvalid=%b bid=%0d want 1 7", bvalid, bid);
        end
        tick();
        $display("fault capture addr=%h wr=%b valid=%b", fault_addr, fault_wr, fault_valid);
    endtask
`else
    task automatic test_fault_disabled();
        do_write(32'h0000_0AB0, 4'd8, 4'd0, 1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (fault_addr !== 32'd0 || fault_wr !== 1'b0 || fault_valid !== 1'b0) begin
            errors++;
            $display("FAIL fault_disabled: addr=%h wr=%b valid=%b want 0 0 0", fault_addr, fault_wr, fault_valid);
        end
        tick();
        $display("fault capture disabled addr=%h valid=%b", fault_addr, fault_valid);
    endtask
`endif

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        awaddr    = '0;
        awlen     = '0;
        awsize    = '0;
        awburst   = '0;
        awid      = '0;
        awvalid   = 1'b0;
        wid       = '0;
        wdata     = '0;
        wstrb     = '0;
        wlast     = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        araddr    = '0;
        arlen     = '0;
        arsize    = '0;
        arburst   = '0;
        arid      = '0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        fault_clr = 1'b0;

        test_reset();
        test_write();
        test_read();
        test_aw_ar_collision();
        test_reset_mid_burst();
`ifdef AXI_APP_MMU_ERR_SLAVE_FAULT_CAPTURE_EN
        test_fault_capture();
`else
        test_fault_disabled();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_app_mmu_err_slave.md
AXI_APP_MMU_ERR_SLAVE -- requirements
Module: axi_app_mmu_err_slave

Interface
REQ-001 SHALL have parameter P_AXI_IDWIDTH, default 4, AXI ID width.
REQ-002 SHALL have parameter P_RESP, default 2'b11, response code driven on bresp/rresp (DECERR).
REQ-003 SHALL have parameter P_RDATA, default 64'h0, constant read data value.
REQ-004 SHALL have ports, one clock, reset asynchronous active-low:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- axis_awaddr/awlen/awsize/awburst/awid/awvalid  in  32/4/3/2/ID/1  AXI3 write address
- axis_awready  out  1  write address ready
- axis_wid/wdata/wstrb/wlast/wvalid  in  ID/64/8/1/1  write data; wid, wdata and wstrb are ignored
- axis_wready  out  1  write data ready
- axis_bresp/bid/bvalid  out  2/ID/1  write response
- axis_bready  in  1  write response ready
- axis_araddr/arlen/arsize/arburst/arid/arvalid  in  32/4/3/2/ID/1  AXI3 read address
- axis_arready  out  1  read address ready
- axis_rdata/rresp/rid/rlast/rvalid  out  64/2/ID/1/1  read data
- axis_rready  in  1  read data ready
- fault_addr  out  32  first captured blocked address
- fault_wr  out  1  captured access was a write
- fault_valid  out  1  capture register holds a fault
- fault_clr  in  1  single-cycle pulse that clears the capture

Function
REQ-005 SHALL use FSM states IDLE, WDATA, WRESP, RDATA, with one transaction outstanding.
REQ-006 IDLE: awready=1; arready=!awvalid, so a write wins a simultaneous AW/AR request.
REQ-007 SHALL register awid/arid on handshake; IDLE->WDATA on AW handshake, IDLE->RDATA on AR handshake.
REQ-008 WDATA: wready=1; each W handshake is consumed; a beat with wlast=1 moves to WRESP, regardless of awlen.
REQ-009 WRESP: bvalid=1, bresp=P_RESP, bid=captured ID, held stable until bready; the B handshake returns to IDLE.
REQ-010 RDATA: SHALL return exactly arlen+1 beats with a 4-bit down-counter loaded with arlen; rvalid=1, rdata=P_RDATA, rresp=P_RESP, rid=captured ID.
REQ-011 rlast=1 only when the counter is 0; the handshake of that beat returns to IDLE.
REQ-012 Outputs SHALL hold stable while valid=1 and ready=0.
REQ-013 Latency: AW handshake in cycle N gives wready in N+1; last W in N gives bvalid in N+1; AR in N gives first rvalid in N+1.
REQ-014 awready/arready SHALL be 0 in every non-IDLE state; no new address is accepted until the response completes.
REQ-015 awsize, awburst, arsize and arburst SHALL be ignored.

Reset
REQ-016 rst_n low SHALL asynchronously force IDLE.
REQ-017 Reset values: bvalid=0, rvalid=0, rlast=0, wready=0, bid=0, rid=0, counter=0, fault_valid=0, fault_addr=0, fault_wr=0.
REQ-018 Reset mid-burst SHALL abandon the transaction with no partial response after release.
REQ-019 awready SHALL return to 1 on the first clock edge after rst_n deasserts.

Configuration
REQ-020 Macro AXI_APP_MMU_ERR_SLAVE_FAULT_CAPTURE_EN defined: on an AW/AR handshake with fault_valid=0, SHALL load fault_addr, fault_wr and set fault_valid=1.
REQ-021 With the macro defined, later faults SHALL be ignored while fault_valid=1.
REQ-022 With the macro defined, fault_clr SHALL clear fault_valid next cycle; fault_clr coincident with a new handshake SHALL record the new fault with fault_valid=1.
REQ-023 Macro undefined: fault_addr, fault_wr and fault_valid SHALL be constant 0, fault_clr SHALL be unused, and no capture flops SHALL be present.

Verification
REQ-024 AW addr=0x0200_1000 id=3 len=3, 4 W beats with wlast on beat 4, bready=1 -> exactly one B, bid=3, bresp=2'b11, one cycle after the last W.
REQ-025 AR id=5 len=7, rready=1 -> 8 beats, rdata=0, rresp=2'b11, rid=5, rlast on beat 8 only.
REQ-026 AR len=0 with rready toggling 0/1 -> single beat with rlast=1, outputs stable while stalled.
REQ-027 awvalid and arvalid asserted in the same cycle -> write accepted first; read accepted only after the B handshake.
REQ-028 rst_n pulsed low during beat 3 of an 8-beat read -> rvalid=0 immediately; awready=1 after release; no stray beats.
REQ-029 Macro defined: faults at 0x100 (read) then 0x200 (write) -> fault_addr=0x100, fault_wr=0; fault_clr together with an AW at 0x300 -> fault_addr=0x300, fault_wr=1, fault_valid=1.
